// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and types for the 2D-DCT datapath
package dct_pkg;

  localparam int PX_WIDTH       = 8;
  // Row-DCT output: 8-bit pixel, 8-point sum grows by 3 bits after rounding.
  localparam int DEF_COEF_WIDTH = PX_WIDTH + 3;
  localparam int BLOCK_SIZE     = 8;
  localparam int BLOCK_PX       = BLOCK_SIZE * BLOCK_SIZE;

  typedef logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][DEF_COEF_WIDTH-1:0] coef_block_t;

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - minimal stream interface with frame/line markers
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/dct_transpose_bank.sv
// rtl/dct_transpose_bank.sv - one 8x8 coefficient bank, element write / column read
module dct_transpose_bank
  import dct_pkg::*;
#(
  parameter int COEF_WIDTH = DEF_COEF_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   i_we,
  input  logic [2:0]                             i_row,
  input  logic [2:0]                             i_col,
  input  logic [COEF_WIDTH-1:0]                  i_data,
  input  logic [2:0]                             i_rd_col,
  output logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0]  o_lanes
);

  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEF_WIDTH-1:0] r_mem;

  // Store one coefficient at (row, col); storage clears on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_row][i_col] <= i_data;
    end
  end

  // Column read: lane i carries row i of the selected column.
  always_comb begin
    o_lanes = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      o_lanes[i] = r_mem[i][i_rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// rtl/dct_transpose.sv - ping-pong 8x8 transpose between row and column DCT passes
module dct_transpose
  import dct_pkg::*;
#(
  parameter int COEF_WIDTH      = DEF_COEF_WIDTH,
  parameter int IN_TDATA_WIDTH  = 16,
  parameter int OUT_TDATA_WIDTH = 88
) (
  input  logic           clk_i,
  input  logic           rst_i,
  axi4_stream_if.slave   coef_i,
  axi4_stream_if.master  coef_o
);

  logic [5:0] r_wr_cnt;
  logic [2:0] r_rd_col;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] r_full;
  logic [1:0] r_user;
  logic [1:0] r_last;

  logic       w_wr_hs;
  logic       w_rd_hs;
  logic [1:0] w_full_nxt;
  logic [1:0] w_we;
  logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0] w_lanes [2];
  logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0] w_rd_lanes;
  logic       w_unused_tdata;

  assign w_wr_hs = coef_i.tvalid && coef_i.tready;
  assign w_rd_hs = coef_o.tvalid && coef_o.tready;
  assign w_we[0] = w_wr_hs && (r_wr_bank == 1'b0);
  assign w_we[1] = w_wr_hs && (r_wr_bank == 1'b1);

  // Bits above COEF_WIDTH on the input bus carry nothing.
  assign w_unused_tdata = ^coef_i.tdata;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_transpose_bank #(
      .COEF_WIDTH (COEF_WIDTH)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_we     (w_we[b]),
      .i_row    (r_wr_cnt[5:3]),
      .i_col    (r_wr_cnt[2:0]),
      .i_data   (coef_i.tdata[COEF_WIDTH-1:0]),
      .i_rd_col (r_rd_col),
      .o_lanes  (w_lanes[b])
    );
  end

  assign w_rd_lanes    = r_rd_bank ? w_lanes[1] : w_lanes[0];

  assign coef_i.tready = !r_full[r_wr_bank];
  assign coef_o.tvalid = r_full[r_rd_bank];
  assign coef_o.tdata  = OUT_TDATA_WIDTH'(w_rd_lanes);
  assign coef_o.tuser  = r_user[r_rd_bank] && (r_rd_col == 3'd0);
  assign coef_o.tlast  = r_last[r_rd_bank] && (r_rd_col == 3'd7);

  // Full flags: the write side sets its bank on the 64th beat while the read
  // side clears its bank after column 7; they never target the same bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_hs && (r_rd_col == 3'd7)) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_wr_hs && (r_wr_cnt == 6'd63)) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  // Write/read pointers, bank flags and full bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_cnt  <= '0;
      r_rd_col  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
      r_user    <= '0;
      r_last    <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_hs) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (r_wr_cnt == 6'd0) begin
          r_user[r_wr_bank] <= coef_i.tuser;
          r_last[r_wr_bank] <= coef_i.tlast;
        end else begin
          r_last[r_wr_bank] <= r_last[r_wr_bank] | coef_i.tlast;
        end
        if (r_wr_cnt == 6'd63) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_rd_hs) begin
        r_rd_col <= r_rd_col + 3'd1;
        if (r_rd_col == 3'd7) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// tb/tb_dct_transpose.sv - directed checks of the 8x8 transpose buffer
module tb_dct_transpose;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;

  axi4_stream_if #(.DATA_WIDTH(16)) s_if ();
  axi4_stream_if #(.DATA_WIDTH(88)) m_if ();

  dct_transpose #(
    .COEF_WIDTH      (11),
    .IN_TDATA_WIDTH  (16),
    .OUT_TDATA_WIDTH (88)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .coef_i (s_if),
    .coef_o (m_if)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [87:0] d;
    logic        u;
    logic        l;
    int          c;
  } beat_t;

  beat_t out_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    in_cnt = 0;
  int    last_in_cyc = -1;
  int    tv_rise_cyc = -1;
  int    stalls = 0;
  logic  prev_tv = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] val(input int mode, input int blk, input int r, input int c);
    if (mode == 1) return (((r + c) % 2) != 0) ? 11'h7FF : 11'h400;
    return 11'(blk * 64 + r * 8 + c);
  endfunction

  function automatic logic [87:0] exp_col(input int mode, input int blk, input int c);
    logic [87:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[i*11 +: 11] = val(mode, blk, i, c);
    return e;
  endfunction

  // Observe both handshakes half a cycle before the edge that completes them.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_if.tvalid && m_if.tready)
        out_q.push_back(beat_t'{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast, c: cyc});
      if (s_if.tvalid && s_if.tready) begin
        in_cnt++;
        if (in_cnt % 64 == 0) last_in_cyc = cyc;
      end
      if (s_if.tvalid && !s_if.tready) stalls++;
      if (m_if.tvalid && !prev_tv) tv_rise_cyc = cyc;
      prev_tv = m_if.tvalid;
    end
  end

  task automatic send(input int mode, input int blk, input int nb, input logic u, input logic l);
    for (int b = 0; b < nb; b++) begin
      bit ok;
      s_if.tdata  = 16'(val(mode, blk, b / 8, b % 8));
      s_if.tuser  = u && (b == 0);
      s_if.tlast  = l && (b == 7 || b == 63);
      s_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 500 && !ok; t++) begin
        @(negedge clk_i);
        ok = s_if.tready;
        @(posedge clk_i);
        #1;
      end
      if (!ok) begin
        chk("send_timeout", 128'(ok), 128'd1);
        return;
      end
    end
  endtask

  task automatic wait_beats(input int n, input string tag);
    int t;
    t = 0;
    while (out_q.size() < n && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    chk(tag, 128'(out_q.size()), 128'(n));
  endtask

  task automatic check_block(input int mode, input int blk, input logic eu, input logic el, input string tag);
    beat_t bt;
    for (int c = 0; c < 8; c++) begin
      if (out_q.size() == 0) begin
        chk({tag, "_missing"}, 128'(c), 128'd8);
        return;
      end
      bt = out_q.pop_front();
      chk($sformatf("%s_data_c%0d", tag, c), 128'(bt.d), 128'(exp_col(mode, blk, c)));
      chk($sformatf("%s_user_c%0d", tag, c), 128'(bt.u), 128'(eu && (c == 0)));
      chk($sformatf("%s_last_c%0d", tag, c), 128'(bt.l), 128'(el && (c == 7)));
    end
  endtask

  task automatic do_reset();
    #3;
    rst_i = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    out_q.delete();
    in_cnt = 0;
    stalls = 0;
    prev_tv = 1'b0;
    tv_rise_cyc = -1;
    last_in_cyc = -1;
  endtask

  initial begin
    int  idx;
    int  tr_cyc;
    bit  seen;

    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_tvalid", 128'(m_if.tvalid), 128'd0);
    chk("rst_tuser",  128'(m_if.tuser),  128'd0);
    chk("rst_tlast",  128'(m_if.tlast),  128'd0);
    chk("rst_tready", 128'(s_if.tready), 128'd1);
    rst_i = 1'b0;

    // Single block, row*8+col pattern, latency of first tvalid.
    send(0, 0, 64, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    wait_beats(8, "t1_beats");
    chk("t1_latency", 128'(tv_rise_cyc - last_in_cyc), 128'd1);
    check_block(0, 0, 1'b0, 1'b0, "t1");

    // Four back-to-back blocks with no input stall.
    do_reset();
    for (int b = 0; b < 4; b++) send(0, b, 64, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    chk("t2_stalls", 128'(stalls), 128'd0);
    wait_beats(32, "t2_beats");
    for (int b = 0; b < 4; b++) check_block(0, b, 1'b0, 1'b0, $sformatf("t2_b%0d", b));

    // Output backpressure: both banks fill, then ready returns after column 7.
    do_reset();
    m_if.tready = 1'b0;
    idx = 0;
    for (int t = 0; t < 300; t++) begin
      s_if.tdata  = 16'(val(0, idx / 64, (idx % 64) / 8, idx % 8));
      s_if.tvalid = 1'b1;
      @(negedge clk_i);
      if (s_if.tready) idx++;
      @(posedge clk_i);
      #1;
    end
    chk("t3_accepted", 128'(idx), 128'd128);
    chk("t3_tready_low", 128'(s_if.tready), 128'd0);
    m_if.tready = 1'b1;
    seen = 1'b0;
    tr_cyc = -1;
    for (int t = 0; t < 100 && !seen; t++) begin
      s_if.tdata  = 16'(val(0, idx / 64, (idx % 64) / 8, idx % 8));
      s_if.tvalid = 1'b1;
      @(negedge clk_i);
      if (s_if.tready) begin
        seen = 1'b1;
        tr_cyc = cyc;
        idx++;
      end
      @(posedge clk_i);
      #1;
    end
    s_if.tvalid = 1'b0;
    chk("t3_ready_seen", 128'(seen), 128'd1);
    wait_beats(16, "t3_beats");
    if (out_q.size() >= 8) chk("t3_ready_after_col7", 128'(tr_cyc - out_q[7].c), 128'd1);
    check_block(0, 0, 1'b0, 1'b0, "t3_b0");
    check_block(0, 1, 1'b0, 1'b0, "t3_b1");

    // Negative values in a checkerboard, bit-exact.
    do_reset();
    send(1, 0, 64, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    wait_beats(8, "t4_beats");
    check_block(1, 0, 1'b0, 1'b0, "t4");

    // Frame/line flags, then a block without flags.
    do_reset();
    send(0, 1, 64, 1'b1, 1'b1);
    send(0, 2, 64, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    wait_beats(16, "t5_beats");
    check_block(0, 1, 1'b1, 1'b1, "t5_flag");
    check_block(0, 2, 1'b0, 1'b0, "t5_noflag");

    // Asynchronous reset mid-block, then a fresh block.
    do_reset();
    send(0, 5, 30, 1'b0, 1'b0);
    #3;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_tready", 128'(s_if.tready), 128'd1);
    chk("t6_rst_tvalid", 128'(m_if.tvalid), 128'd0);
    s_if.tvalid = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    out_q.delete();
    send(0, 2, 64, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    wait_beats(8, "t6_beats");
    check_block(0, 2, 1'b0, 1'b0, "t6");
    repeat (20) @(negedge clk_i);
    chk("t6_no_stale", 128'(out_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct_transpose.md
Name: dct_transpose

Overview:
- 8x8 transpose buffer between the row-pass dct_1d and the column-pass dct_1d of the 2D-DCT.
- Accepts row-DCT coefficients one per beat, row-major within an 8x8 block.
- Emits each block column-by-column as 8 packed coefficients per beat, which is the 1x8 window format the column-pass dct_1d consumes.
- Ping-pong double buffer, so a continuous input stream never stalls.

Parameters:
- COEF_WIDTH, default 11: signed two's-complement coefficient width. Matches the rounded row-DCT output for 8-bit pixels.
- IN_TDATA_WIDTH, default 16: coef_i tdata width, COEF_WIDTH rounded up to whole bytes. Only bits [COEF_WIDTH-1:0] are used.
- OUT_TDATA_WIDTH, default 88: coef_o tdata width, 8*COEF_WIDTH rounded up to whole bytes. Unused MSBs are driven 0.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- coef_i  axi4_stream_if.slave  IN_TDATA_WIDTH  one coefficient per beat; tuser = first beat of a frame; tlast = end of line
- coef_o  axi4_stream_if.master  OUT_TDATA_WIDTH  one block column per beat; lane i (bits [i*COEF_WIDTH +: COEF_WIDTH]) = row i

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. On reset:
  - coef_o tvalid, tuser and tlast = 0; coef_i tready = 1.
  - wr_cnt, rd_col, wr_bank, rd_bank and full[1:0] = 0; both banks' storage cleared to 0.
- Storage: bank[2][8 rows][8 cols] of COEF_WIDTH flops. Each bank also holds a tuser flag and a tlast flag.
- Write side:
  - coef_i.tready = !full[wr_bank].
  - On handshake: bank[wr_bank][wr_cnt[5:3]][wr_cnt[2:0]] <= tdata[COEF_WIDTH-1:0]; wr_cnt++.
  - Bank tuser flag <= tuser sampled at wr_cnt==0. Bank tlast flag = OR of tlast over all 64 beats.
  - Handshake at wr_cnt==63: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Read side:
  - coef_o.tvalid = full[rd_bank].
  - tdata lane i = bank[rd_bank][i][rd_col]. This is a mux of registers only, with no combinational path from coef_i.
  - tuser = bank tuser flag && rd_col==0. tlast = bank tlast flag && rd_col==7.
  - On handshake rd_col++. At rd_col==7: full[rd_bank] <= 0, rd_bank toggles.
- Latency: coef_o.tvalid rises the cycle after the 64th input handshake of a block, when the read bank is idle.
- Simultaneous events:
  - Setting full on one bank while clearing full on the other in the same cycle is legal; both updates take effect.
  - The write bank is never the bank being read while that bank's full bit is set.
- Full condition: with both banks full, tready=0. Tready returns the cycle after the read side frees a bank by completing column 7.
- Output stall: tdata, tuser and tlast are held stable while tvalid && !tready.
- Reset mid-block: the partial block is discarded and all pointers restart at 0. Reset has no other recovery path.
- No arithmetic is performed; values pass bit-exact and are not sign-extended.
- Throughput: 1 coefficient per clock in. The output side needs 8 beats per 64 input beats, so sustained backpressure of up to 56 of every 64 cycles is absorbed without stalling the input.

Decomposition:
- dct_pkg gains:
  - BLOCK_SIZE = 8
  - BLOCK_PX = 64
  - a coef_block_t typedef: [7:0][7:0][COEF_WIDTH-1:0]
  - the COEF_WIDTH default, derived from PX_WIDTH
- Sub-module dct_transpose_bank: one 8x8 bank with write port (row, col, data, we) and column read port (col → 8 lanes). Instantiated twice.
- Control (counters, pointers, full flags) stays in dct_transpose.

Test Plan:
- Single block, input value = row*8+col, tready_o=1 → output beat c has lane i = i*8+c; first tvalid appears 1 cycle after the 64th input handshake.
- 4 back-to-back blocks, input tvalid held 1, output tready=1 → coef_i.tready never drops; 32 output beats, all correct.
- Output tready=0 for 300 cycles with continuous input → exactly 128 beats accepted, then tready=0. After tready=1, tready returns the cycle after the 8th output beat.
- Negative values: all inputs 11'h400 (-1024) and 11'h7FF (-1) in a checkerboard → lanes bit-exact; upper 0 bits of the 88-bit bus are 0.
- Flags: tuser on block input beat 0, tlast on beats 7 and 63 → output tuser only on beat 0, tlast only on beat 7. A block without tlast gives tlast=0 on all beats.
- Assert rst_i asynchronously after 30 input beats of a block, then send a fresh block → no stale output; the new block transposes correctly from bank 0.
